// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types and constants.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data, execute redirect, and decode valid/ready.
// The fetch_misalign signal exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fetch_misalign;
`endif

    modport master (
        output imem_addr, out_valid, out_inst, out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_misalign,
`endif
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_misalign,
`endif
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer of {pc, inst} entries with push/pop/flush. While empty, the
// output holds the last presented head so decode never sees a glitching bus.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    last_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~flush_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Snapshot the current head so it survives a pop or flush to empty.
            if (!empty_o) last_q <= mem_q[rd_ptr_q];
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, imem addressing, fetch buffer and redirect.
// Optional FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets.
module fetch_unit #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] RESET_PC   = rv32i_pkg::RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    import rv32i_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_tgt;
    logic            push, pop, full, empty, push_ok;
    fetch_entry_t    wr_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redirect_tgt       = bus.redirect_pc;
    assign push_ok            = ~misalign_q;
    assign bus.fetch_misalign = misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (bus.redirect_valid) misalign_d = is_misaligned(bus.redirect_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
`else
    logic unused_redirect_lsb;

    // Low bits are dropped so pc stays word aligned.
    assign redirect_tgt        = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign push_ok             = 1'b1;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
`endif

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = ~bus.redirect_valid & push_ok & (~full | pop);

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = ~empty;
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
    assign wr_entry      = '{pc: pc_q, inst: bus.imem_rdata};

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = redirect_tgt;
        else if (push)          pc_d = pc_q + PC_STEP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule
